msrv32_machine_control: RTL and testbench

- Trap/return sequencer directly downstream of msrv32_decoder.
- Consumes the decoder's illegal_instr and misaligned_load/store flags, plus ECALL/EBREAK/MRET fields and CSR interrupt enables/pendings.
- Produces trap_taken, which feeds the decoder's trap_taken_in, together with PC-source select, pipeline flush and CSR update strobes.
- Four-state FSM, single clock.

---
 rtl/msrv32_machine_control_pkg.sv | 81 ++++++++
 rtl/msrv32_machine_control_if.sv | 56 +++++
 rtl/msrv32_machine_control_trap_prioritiser.sv | 60 ++++++
 rtl/msrv32_machine_control.sv | 111 +++++++++++
 tb/tb_msrv32_machine_control.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/msrv32_machine_control_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
// Holds the FSM state encoding, PC-source selects, mcause codes and SYSTEM
// instruction field values, plus a helper that maps a state to its strobes.
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } state_e;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_NEXT = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_EPC  = 2'b11;

  // Exception codes (mcause with interrupt bit clear)
  localparam logic [3:0] EXC_MISALIGNED_INSTR = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL          = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_MISALIGNED_LOAD  = 4'd4;
  localparam logic [3:0] EXC_MISALIGNED_STORE = 4'd6;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  // Interrupt codes (mcause with interrupt bit set)
  localparam logic [3:0] IRQ_SOFTWARE = 4'd3;
  localparam logic [3:0] IRQ_TIMER    = 4'd7;
  localparam logic [3:0] IRQ_EXTERNAL = 4'd11;

  // SYSTEM instruction fields
  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
  localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
  localparam logic [4:0] RS2_ECALL     = 5'b00000;
  localparam logic [4:0] RS2_EBREAK    = 5'b00001;
  localparam logic [4:0] RS2_MRET      = 5'b00010;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       flush;
    logic       trap_taken;
    logic       set_epc;
    logic       set_cause;
    logic       mie_clear;
    logic       mie_set;
    logic       instret_inc;
  } ctrl_t;

  // Strobe pattern that belongs to each state; anything not set stays 0.
  function automatic ctrl_t ctrl_for_state(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_RESET: begin
        c.pc_src = PC_SRC_BOOT;
        c.flush  = 1'b1;
      end
      ST_OPERATING: begin
        c.pc_src      = PC_SRC_NEXT;
        c.instret_inc = 1'b1;
      end
      ST_TRAP_TAKEN: begin
        c.pc_src     = PC_SRC_TRAP;
        c.flush      = 1'b1;
        c.trap_taken = 1'b1;
        c.set_epc    = 1'b1;
        c.set_cause  = 1'b1;
        c.mie_clear  = 1'b1;
      end
      default: begin
        c.pc_src  = PC_SRC_EPC;
        c.flush   = 1'b1;
        c.mie_set = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/msrv32_machine_control_if.sv
// Bundle between the decode stage and the machine-control sequencer.
// Master drives decoder flags, instruction fields and CSR enables/pendings;
// slave (the sequencer) returns PC select, flush and CSR update strobes.
interface msrv32_machine_control_if #(parameter int CAUSE_W = 4);

  logic               illegal_instr_in;
  logic               misaligned_load_in;
  logic               misaligned_store_in;
  logic               misaligned_instr_in;
  logic [4:0]         opcode_6_to_2_in;
  logic [2:0]         funct3_in;
  logic [6:0]         funct7_in;
  logic [4:0]         rs1_addr_in;
  logic [4:0]         rs2_addr_in;
  logic [4:0]         rd_addr_in;
  logic               mie_in;
  logic               meie_in;
  logic               mtie_in;
  logic               msie_in;
  logic               meip_in;
  logic               mtip_in;
  logic               msip_in;

  logic               trap_taken_out;
  logic [1:0]         pc_src_out;
  logic               flush_out;
  logic               set_epc_out;
  logic               set_cause_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               i_or_e_out;
  logic               mie_clear_out;
  logic               mie_set_out;
  logic               instret_inc_out;
  logic               misaligned_exception_out;

  modport master (
    output illegal_instr_in, misaligned_load_in, misaligned_store_in,
           misaligned_instr_in, opcode_6_to_2_in, funct3_in, funct7_in,
           rs1_addr_in, rs2_addr_in, rd_addr_in, mie_in, meie_in, mtie_in,
           msie_in, meip_in, mtip_in, msip_in,
    input  trap_taken_out, pc_src_out, flush_out, set_epc_out, set_cause_out,
           cause_out, i_or_e_out, mie_clear_out, mie_set_out, instret_inc_out,
           misaligned_exception_out
  );

  modport slave (
    input  illegal_instr_in, misaligned_load_in, misaligned_store_in,
           misaligned_instr_in, opcode_6_to_2_in, funct3_in, funct7_in,
           rs1_addr_in, rs2_addr_in, rd_addr_in, mie_in, meie_in, mtie_in,
           msie_in, meip_in, mtip_in, msip_in,
    output trap_taken_out, pc_src_out, flush_out, set_epc_out, set_cause_out,
           cause_out, i_or_e_out, mie_clear_out, mie_set_out, instret_inc_out,
           misaligned_exception_out
  );

endinterface

// File: rtl/msrv32_machine_control_trap_prioritiser.sv
// Picks the winning trap source and its mcause code.
// Purely combinational, zero latency.
// No flow control: result is valid whenever the inputs are.
module msrv32_trap_prioritiser
  import msrv32_pkg::*;
(
  input  logic       misaligned_instr_in,
  input  logic       illegal_instr_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       misaligned_store_in,
  input  logic       misaligned_load_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       exc_any_out,
  output logic       irq_any_out,
  output logic [3:0] cause_out,
  output logic       i_or_e_out
);

  logic ext_irq;
  logic sw_irq;
  logic tmr_irq;

  // Exceptions win over interrupts; within each class the chain order is fixed.
  always_comb begin
    ext_irq = mie_in & meie_in & meip_in;
    sw_irq  = mie_in & msie_in & msip_in;
    tmr_irq = mie_in & mtie_in & mtip_in;

    exc_any_out = misaligned_instr_in | illegal_instr_in | ecall_in |
                  ebreak_in | misaligned_store_in | misaligned_load_in;
    irq_any_out = ext_irq | sw_irq | tmr_irq;

    cause_out  = 4'd0;
    i_or_e_out = 1'b0;
    if      (misaligned_instr_in) cause_out = EXC_MISALIGNED_INSTR;
    else if (illegal_instr_in)    cause_out = EXC_ILLEGAL;
    else if (ecall_in)            cause_out = EXC_ECALL_M;
    else if (ebreak_in)           cause_out = EXC_BREAKPOINT;
    else if (misaligned_store_in) cause_out = EXC_MISALIGNED_STORE;
    else if (misaligned_load_in)  cause_out = EXC_MISALIGNED_LOAD;
    else if (ext_irq) begin
      cause_out  = IRQ_EXTERNAL;
      i_or_e_out = 1'b1;
    end else if (sw_irq) begin
      cause_out  = IRQ_SOFTWARE;
      i_or_e_out = 1'b1;
    end else if (tmr_irq) begin
      cause_out  = IRQ_TIMER;
      i_or_e_out = 1'b1;
    end
  end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer: RESET/OPERATING/TRAP_TAKEN/TRAP_RETURN.
// Trap sampled in OPERATING shows as trap_taken_out one cycle later, for one cycle.
// No backpressure: trap/irq inputs are ignored outside OPERATING.
module msrv32_machine_control
  import msrv32_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic                     ms_riscv32_mp_clk_in,
  input  logic                     ms_riscv32_mp_rst_in,
  msrv32_machine_control_if.slave  mc
);

  logic         is_priv;
  logic         ecall;
  logic         ebreak;
  logic         mret;
  logic         exc_any;
  logic         irq_any;
  logic [3:0]   pri_cause;
  logic         pri_i_or_e;

  state_e       state_q, state_d;
  ctrl_t        ctrl_q, ctrl_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic         i_or_e_q, i_or_e_d;

  // Decode the privileged SYSTEM instructions from the raw fields.
  always_comb begin
    is_priv = (mc.opcode_6_to_2_in == OPCODE_SYSTEM) &&
              (mc.funct3_in == FUNCT3_PRIV) &&
              (mc.rs1_addr_in == 5'd0) && (mc.rd_addr_in == 5'd0);
    ecall   = is_priv && (mc.funct7_in == FUNCT7_ECALL) && (mc.rs2_addr_in == RS2_ECALL);
    ebreak  = is_priv && (mc.funct7_in == FUNCT7_ECALL) && (mc.rs2_addr_in == RS2_EBREAK);
    mret    = is_priv && (mc.funct7_in == FUNCT7_MRET)  && (mc.rs2_addr_in == RS2_MRET);
  end

  msrv32_trap_prioritiser u_prio (
    .misaligned_instr_in (mc.misaligned_instr_in),
    .illegal_instr_in    (mc.illegal_instr_in),
    .ecall_in            (ecall),
    .ebreak_in           (ebreak),
    .misaligned_store_in (mc.misaligned_store_in),
    .misaligned_load_in  (mc.misaligned_load_in),
    .mie_in              (mc.mie_in),
    .meie_in             (mc.meie_in),
    .mtie_in             (mc.mtie_in),
    .msie_in             (mc.msie_in),
    .meip_in             (mc.meip_in),
    .mtip_in             (mc.mtip_in),
    .msip_in             (mc.msip_in),
    .exc_any_out         (exc_any),
    .irq_any_out         (irq_any),
    .cause_out           (pri_cause),
    .i_or_e_out          (pri_i_or_e)
  );

  // Next state, and cause capture only on the OPERATING -> TRAP_TAKEN edge.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    i_or_e_d = i_or_e_q;
    case (state_q)
      ST_RESET: state_d = ST_OPERATING;
      ST_OPERATING: begin
        if (exc_any || irq_any) begin
          state_d  = ST_TRAP_TAKEN;
          cause_d  = CAUSE_W'(pri_cause);
          i_or_e_d = pri_i_or_e;
        end else if (mret) begin
          state_d = ST_TRAP_RETURN;
        end
      end
      default: state_d = ST_OPERATING;
    endcase
    // Strobes are precomputed for the next state so they come straight off flops.
    ctrl_d = ctrl_for_state(state_d);
  end

  // FSM state, state-decoded strobes and held cause; reset aborts any sequence.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q  <= ST_RESET;
      ctrl_q   <= ctrl_for_state(ST_RESET);
      cause_q  <= '0;
      i_or_e_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      cause_q  <= cause_d;
      i_or_e_q <= i_or_e_d;
    end
  end

  // Drive the bundle; the misaligned summary is gated by the live state.
  always_comb begin
    mc.trap_taken_out  = ctrl_q.trap_taken;
    mc.pc_src_out      = ctrl_q.pc_src;
    mc.flush_out       = ctrl_q.flush;
    mc.set_epc_out     = ctrl_q.set_epc;
    mc.set_cause_out   = ctrl_q.set_cause;
    mc.mie_clear_out   = ctrl_q.mie_clear;
    mc.mie_set_out     = ctrl_q.mie_set;
    mc.instret_inc_out = ctrl_q.instret_inc;
    mc.cause_out       = cause_q;
    mc.i_or_e_out      = i_or_e_q;
    mc.misaligned_exception_out = (state_q == ST_OPERATING) &&
        (mc.misaligned_instr_in || mc.misaligned_load_in || mc.misaligned_store_in);
  end

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed plus randomized bench for the machine-control sequencer.
// Expected outputs come from a rule-level reference model stepped each edge.
// Outputs are compared on the falling edge, inputs change after it.
module tb_msrv32_machine_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msrv32_machine_control_if #(.CAUSE_W(4)) bus ();

  msrv32_machine_control #(.CAUSE_W(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .mc                   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 reset, 1 running, 2 in trap entry, 3 in return.
  int       m_mode  = 0;
  int       m_cause = 0;
  int       m_ioe   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.illegal_instr_in    = 0;
    bus.misaligned_load_in  = 0;
    bus.misaligned_store_in = 0;
    bus.misaligned_instr_in = 0;
    bus.opcode_6_to_2_in    = 0;
    bus.funct3_in           = 0;
    bus.funct7_in           = 0;
    bus.rs1_addr_in         = 0;
    bus.rs2_addr_in         = 0;
    bus.rd_addr_in          = 0;
    bus.mie_in  = 0; bus.meie_in = 0; bus.mtie_in = 0; bus.msie_in = 0;
    bus.meip_in = 0; bus.mtip_in = 0; bus.msip_in = 0;
  endtask

  task automatic set_sys(input int f7, input int rs2);
    bus.opcode_6_to_2_in = 5'b11100;
    bus.funct3_in        = 0;
    bus.rs1_addr_in      = 0;
    bus.rd_addr_in       = 0;
    bus.funct7_in        = 7'(f7);
    bus.rs2_addr_in      = 5'(rs2);
  endtask

  // Apply the architectural rules to whatever inputs are present at the edge.
  task automatic model_step();
    bit sys;
    int exc_code[6];
    bit exc_hit[6];
    int irq_code[3];
    bit irq_hit[3];
    int won;
    bit mret;
    if (rst) begin
      m_mode = 0; m_cause = 0; m_ioe = 0;
      return;
    end
    if (m_mode != 1) begin
      m_mode = 1;
      return;
    end
    sys = (bus.opcode_6_to_2_in == 5'b11100) && (bus.funct3_in == 0) &&
          (bus.rs1_addr_in == 0) && (bus.rd_addr_in == 0);
    exc_code = '{0, 2, 11, 3, 6, 4};
    exc_hit[0] = bus.misaligned_instr_in;
    exc_hit[1] = bus.illegal_instr_in;
    exc_hit[2] = sys && bus.funct7_in == 0 && bus.rs2_addr_in == 0;
    exc_hit[3] = sys && bus.funct7_in == 0 && bus.rs2_addr_in == 1;
    exc_hit[4] = bus.misaligned_store_in;
    exc_hit[5] = bus.misaligned_load_in;
    irq_code = '{11, 3, 7};
    irq_hit[0] = bus.mie_in && bus.meie_in && bus.meip_in;
    irq_hit[1] = bus.mie_in && bus.msie_in && bus.msip_in;
    irq_hit[2] = bus.mie_in && bus.mtie_in && bus.mtip_in;
    mret = sys && bus.funct7_in == 7'b0011000 && bus.rs2_addr_in == 2;
    won = -1;
    for (int i = 5; i >= 0; i--) if (exc_hit[i]) won = i;
    if (won >= 0) begin
      m_mode = 2; m_cause = exc_code[won]; m_ioe = 0;
      return;
    end
    for (int i = 2; i >= 0; i--) if (irq_hit[i]) won = i;
    if (won >= 0) begin
      m_mode = 2; m_cause = irq_code[won]; m_ioe = 1;
    end else if (mret) begin
      m_mode = 3;
    end
  endtask

  task automatic check_all(input string tag);
    int mis;
    mis = (m_mode == 1) && (bus.misaligned_instr_in || bus.misaligned_load_in ||
                            bus.misaligned_store_in);
    // pc_src values line up one-to-one with the four modes.
    chk({tag, ".pc_src"},      int'(bus.pc_src_out),      m_mode);
    chk({tag, ".flush"},       int'(bus.flush_out),       int'(m_mode != 1));
    chk({tag, ".trap_taken"},  int'(bus.trap_taken_out),  int'(m_mode == 2));
    chk({tag, ".set_epc"},     int'(bus.set_epc_out),     int'(m_mode == 2));
    chk({tag, ".set_cause"},   int'(bus.set_cause_out),   int'(m_mode == 2));
    chk({tag, ".mie_clear"},   int'(bus.mie_clear_out),   int'(m_mode == 2));
    chk({tag, ".mie_set"},     int'(bus.mie_set_out),     int'(m_mode == 3));
    chk({tag, ".instret_inc"}, int'(bus.instret_inc_out), int'(m_mode == 1));
    chk({tag, ".cause"},       int'(bus.cause_out),       m_cause);
    chk({tag, ".i_or_e"},      int'(bus.i_or_e_out),      m_ioe);
    chk({tag, ".misaligned"},  int'(bus.misaligned_exception_out), mis);
  endtask

  // One clock: model follows the DUT edge, then compare on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step("rst0"); step("rst1"); step("rst2");
    rst = 0;
    step("boot");
    chk("boot.pc_src_lit", int'(bus.pc_src_out), 1);

    bus.illegal_instr_in = 1;
    step("illegal");
    chk("illegal.cause_lit", int'(bus.cause_out), 2);
    bus.illegal_instr_in = 0;
    step("illegal_ret");

    set_sys(7'b0011000, 2);
    step("mret");
    chk("mret.pc_src_lit", int'(bus.pc_src_out), 3);
    clear_inputs();
    step("mret_done");

    bus.mie_in = 1; bus.meie_in = 1; bus.meip_in = 1; bus.mtie_in = 1; bus.mtip_in = 1;
    step("irq_ext");
    chk("irq_ext.cause_lit", int'(bus.cause_out), 11);
    step("irq_ignored_in_trap");
    bus.mie_in = 0;
    step("irq_masked0");
    step("irq_masked1");
    clear_inputs();

    bus.misaligned_load_in = 1;
    set_sys(0, 0);
    step("ecall_vs_load");
    chk("ecall_vs_load.cause_lit", int'(bus.cause_out), 11);
    clear_inputs();
    step("gap0");
    bus.misaligned_load_in = 1;
    set_sys(7'b0011000, 2);
    step("load_vs_mret");
    clear_inputs();
    step("gap1");
    bus.misaligned_load_in = 1;
    step("load_alone");
    chk("load_alone.cause_lit", int'(bus.cause_out), 4);
    clear_inputs();
    step("gap2");

    bus.illegal_instr_in = 1;
    step("pre_abort");
    clear_inputs();
    rst = 1;
    step("abort");
    chk("abort.pc_src_lit", int'(bus.pc_src_out), 0);
    rst = 0;
    step("abort_boot");

    for (int c = 0; c < 600; c++) begin
      int sel;
      clear_inputs();
      rst = ($urandom_range(0, 49) == 0);
      bus.illegal_instr_in    = ($urandom_range(0, 9) == 0);
      bus.misaligned_load_in  = ($urandom_range(0, 9) == 0);
      bus.misaligned_store_in = ($urandom_range(0, 9) == 0);
      bus.misaligned_instr_in = ($urandom_range(0, 11) == 0);
      bus.mie_in  = $urandom_range(0, 1);
      bus.meie_in = $urandom_range(0, 1); bus.meip_in = ($urandom_range(0, 3) == 0);
      bus.msie_in = $urandom_range(0, 1); bus.msip_in = ($urandom_range(0, 3) == 0);
      bus.mtie_in = $urandom_range(0, 1); bus.mtip_in = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: set_sys(0, 0);
        1: set_sys(0, 1);
        2, 3: set_sys(7'b0011000, 2);
        4: begin
          set_sys(7'b0011000, 2);
          bus.rd_addr_in = 5'($urandom_range(0, 1));
          bus.funct3_in  = 3'($urandom_range(0, 1));
        end
        default: begin
          bus.opcode_6_to_2_in = 5'($urandom);
          bus.funct7_in        = 7'($urandom);
          bus.rs2_addr_in      = 5'($urandom);
        end
      endcase
      step("rand");
    end

    rst = 0;
    clear_inputs();
    step("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
